// File: rtl/mac_pkg.sv
// Shared types and arithmetic helpers for the pipelined signed MAC.
package mac_pkg;

   localparam int unsigned MAX_MULT_STAGES = 3;
   localparam int unsigned MAX_ACC_W       = 63;

   typedef logic signed [MAX_ACC_W:0] acc_wide_t;

   typedef struct packed {
      logic valid;
      logic clear;
   } tag_t;

   // Overflow of a wf-bit accumulate: the top two bits of the wf+1-bit sum disagree.
   function automatic logic add_ovf(input acc_wide_t addend, input acc_wide_t prod,
                                    input int unsigned wf);
      acc_wide_t  sum;
      logic [1:0] top;
      sum = addend + prod;
      top = 2'(sum >>> (wf - 1));
      return top[1] ^ top[0];
   endfunction

   // Sum of two sign-extended wf-bit values; clamps to the wf-bit range when saturate
   // is set, otherwise returns the raw sum and the caller keeps the low wf bits.
   function automatic acc_wide_t sat_add(input acc_wide_t addend, input acc_wide_t prod,
                                         input int unsigned wf, input logic saturate);
      acc_wide_t  sum;
      acc_wide_t  pos_max;
      acc_wide_t  neg_min;
      logic [1:0] top;
      sum     = addend + prod;
      top     = 2'(sum >>> (wf - 1));
      pos_max = (acc_wide_t'(1) <<< (wf - 1)) - acc_wide_t'(1);
      neg_min = ~pos_max;
      if (saturate && (top[1] != top[0])) begin
         return top[1] ? neg_min : pos_max;
      end
      return sum;
   endfunction

endpackage

// File: rtl/part2_mac_pipe_mult.sv
// Full-precision signed multiplier followed by a register chain carrying product and tag.
module mult_pipe
   import mac_pkg::*;
#(
   parameter int unsigned WIDTH_A     = 10,
   parameter int unsigned WIDTH_B     = 10,
   parameter int unsigned MULT_STAGES = 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic signed [WIDTH_A-1:0]        a,
   input  logic signed [WIDTH_B-1:0]        b,
   input  tag_t                             tag_in,
   output logic signed [WIDTH_A+WIDTH_B-1:0] prod,
   output tag_t                             tag_out
);

   localparam int unsigned WIDTH_P = WIDTH_A + WIDTH_B;

   logic signed [WIDTH_P-1:0] prod_c;

   assign prod_c = WIDTH_P'(a) * WIDTH_P'(b);

   generate
      if (MULT_STAGES == 0) begin : g_comb
         assign prod    = prod_c;
         assign tag_out = tag_in;
      end else begin : g_regs
         logic signed [WIDTH_P-1:0] prod_q [MULT_STAGES];
         tag_t                      tag_q  [MULT_STAGES];

         // Product and tag advance together so the tag always labels its own data.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < MULT_STAGES; i++) begin
                  prod_q[i] <= '0;
                  tag_q[i]  <= '0;
               end
            end else begin
               prod_q[0] <= prod_c;
               tag_q[0]  <= tag_in;
               for (int i = 1; i < MULT_STAGES; i++) begin
                  prod_q[i] <= prod_q[i-1];
                  tag_q[i]  <= tag_q[i-1];
               end
            end
         end

         assign prod    = prod_q[MULT_STAGES-1];
         assign tag_out = tag_q[MULT_STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/part2_mac_pipe.sv
// Pipelined signed multiply-accumulate: input stage, multiplier pipe, accumulate stage.
module part2_mac_pipe
   import mac_pkg::*;
#(
   parameter int unsigned WIDTH_A     = 10,
   parameter int unsigned WIDTH_B     = 10,
   parameter int unsigned WIDTH_F     = 20,
   parameter int unsigned MULT_STAGES = 1,
   parameter bit          SATURATE    = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic signed [WIDTH_A-1:0] a,
   input  logic signed [WIDTH_B-1:0] b,
   input  logic                      valid_in,
   input  logic                      clear_in,
   output logic signed [WIDTH_F-1:0] f,
   output logic                      valid_out,
   output logic                      overflow
);

   localparam int unsigned WIDTH_P = WIDTH_A + WIDTH_B;
   localparam int unsigned STAGES  = (MULT_STAGES > MAX_MULT_STAGES) ? MAX_MULT_STAGES
                                                                     : MULT_STAGES;

   logic signed [WIDTH_A-1:0] a_q;
   logic signed [WIDTH_B-1:0] b_q;
   tag_t                      in_tag_q;
   logic signed [WIDTH_P-1:0] prod;
   tag_t                      acc_tag;
   acc_wide_t                 prod_w;
   acc_wide_t                 addend_w;

   // Operands only load on accepted samples; clear is meaningless without valid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_q      <= '0;
         b_q      <= '0;
         in_tag_q <= '0;
      end else begin
         in_tag_q.valid <= valid_in;
         in_tag_q.clear <= valid_in & clear_in;
         if (valid_in) begin
            a_q <= a;
            b_q <= b;
         end
      end
   end

   mult_pipe #(
      .WIDTH_A     (WIDTH_A),
      .WIDTH_B     (WIDTH_B),
      .MULT_STAGES (STAGES)
   ) u_mult (
      .clk     (clk),
      .reset   (reset),
      .a       (a_q),
      .b       (b_q),
      .tag_in  (in_tag_q),
      .prod    (prod),
      .tag_out (acc_tag)
   );

   assign prod_w   = acc_wide_t'(prod);
   assign addend_w = acc_tag.clear ? '0 : acc_wide_t'(f);

   // A clear sample restarts both the sum and the sticky overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         f         <= '0;
         valid_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         valid_out <= acc_tag.valid;
         if (acc_tag.valid) begin
            f        <= WIDTH_F'(sat_add(addend_w, prod_w, WIDTH_F, SATURATE));
            overflow <= acc_tag.clear ? 1'b0
                                      : (overflow | add_ovf(addend_w, prod_w, WIDTH_F));
         end
      end
   end

endmodule
